// File: rtl/fpu_div_arbiter.sv
// Round-robin arbiter sharing one Goldschmidt divider between NREQ FPU issue ports.
// Optional WAIT-state abort timer is enabled by defining FPU_DIV_TIMEOUT_EN.
module fpu_div_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_dividend,
    input  logic [NREQ*W-1:0] req_divisor,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_quotient,
    output logic [W-1:0]      rsp_rem,
    output logic              rsp_err,
    output logic              arb_busy,
    output logic [W-1:0]      div_dividend,
    output logic [W-1:0]      div_divisor,
    output logic              div_start,
    input  logic              div_busy,
    input  logic              div_ready,
    input  logic [W-1:0]      div_quotient,
    input  logic [W-1:0]      div_rem,
    output logic [1:0]        state_dbg
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  ptr, owner, gnt_idx, scan_idx;
    logic           gnt_found, capture, abort;
    logic [W-1:0]   dvd_arr [NREQ];
    logic [W-1:0]   dvs_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign dvd_arr[i] = req_dividend[i*W +: W];
        assign dvs_arr[i] = req_divisor[i*W +: W];
    end

    // First pending request scanning upward from the round-robin pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = PW'((int'(ptr) + i) % NREQ);
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

`ifdef FPU_DIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_expired;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)             tmo_cnt <= '0;
        else if (state != WAIT) tmo_cnt <= '0;
        else                   tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_expired = (tmo_cnt == CW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Grants are gated by clrn so a held request cannot pulse req_ready during reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        div_start = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found && clrn) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_nxt          = ISSUE;
                end
            end
            ISSUE: begin
                div_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (div_ready) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
`ifdef FPU_DIV_TIMEOUT_EN
                else if (tmo_expired) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ptr          <= '0;
            owner        <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_quotient <= '0;
            rsp_rem      <= '0;
        end else begin
            if (state == IDLE && gnt_found) begin
                div_dividend <= dvd_arr[gnt_idx];
                div_divisor  <= dvs_arr[gnt_idx];
                owner        <= gnt_idx;
                ptr          <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (capture) begin
                rsp_quotient <= div_quotient;
                rsp_rem      <= div_rem;
            end else if (abort) begin
                rsp_quotient <= '0;
                rsp_rem      <= '0;
            end
        end
    end

`ifdef FPU_DIV_TIMEOUT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)        rsp_err <= 1'b0;
        else if (capture) rsp_err <= 1'b0;
        else if (abort)   rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    assign arb_busy  = (state != IDLE);
    assign state_dbg = state;

    // div_busy is informational only; the handshake completes on div_ready.
    logic unused_ok;
    assign unused_ok = ^{div_busy, (TIMEOUT > 0)};

endmodule

// File: tb/tb_fpu_div_arbiter.sv
// Directed bench for fpu_div_arbiter: the bench plays both the requesters and the divider.
// Define FPU_DIV_TIMEOUT_EN on both files to include the WAIT abort sequence.
module tb_fpu_div_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              clrn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_dividend;
    logic [NREQ*W-1:0] req_divisor;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_rem;
    logic              rsp_err;
    logic              arb_busy;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_start;
    logic              div_busy;
    logic              div_ready;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_rem;
    logic [1:0]        state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    fpu_div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .clrn         (clrn),
        .req_valid    (req_valid),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .rsp_rem      (rsp_rem),
        .rsp_err      (rsp_err),
        .arb_busy     (arb_busy),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_busy     (div_busy),
        .div_ready    (div_ready),
        .div_quotient (div_quotient),
        .div_rem      (div_rem),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int port, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        req_dividend[port*W +: W] = dvd;
        req_divisor[port*W +: W]  = dvs;
    endtask

    // Called at a negedge (+#1 not yet elapsed) with the arbiter IDLE and port's request up.
    // Returns at the following IDLE negedge, after the post-response checks.
    task automatic serve(input int port, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input logic [W-1:0] q, input logic [W-1:0] r, input int lat,
                         input logic [NREQ-1:0] raise_m, input logic [NREQ-1:0] drop_m,
                         input bit glitch);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << port;
        #1;
        chk("grant", req_ready, oh);
        @(negedge clk);
        req_valid[port] = 1'b0;
        if (glitch) begin
            div_ready    = 1'b1;
            div_quotient = 32'hDEAD_BEEF;
            div_rem      = 32'h0000_0BAD;
        end
        #1;
        chk("issue_start", div_start, 1);
        chk("issue_dvd", div_dividend, dvd);
        chk("issue_dvs", div_divisor, dvs);
        chk("issue_nogrant", req_ready, 0);
        @(negedge clk);
        div_ready = 1'b0;
        req_valid = req_valid | raise_m;
        for (int i = 0; i < lat; i++) begin
            #1;
            chk("wait_start", div_start, 0);
            chk("wait_nogrant", req_ready, 0);
            chk("wait_norsp", rsp_valid, 0);
            chk("wait_busy", arb_busy, 1);
            @(negedge clk);
        end
        div_ready    = 1'b1;
        div_quotient = q;
        div_rem      = r;
        @(negedge clk);
        div_ready    = 1'b0;
        div_quotient = 32'h1234_5678;
        div_rem      = 32'h8765_4321;
        req_valid    = req_valid & ~drop_m;
        #1;
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_quot", rsp_quotient, q);
        chk("rsp_rem", rsp_rem, r);
        chk("rsp_err", rsp_err, 0);
        chk("rsp_nogrant", req_ready, 0);
        @(negedge clk);
        #1;
        chk("idle_norsp", rsp_valid, 0);
        chk("idle_busy", arb_busy, 0);
        chk("hold_quot", rsp_quotient, q);
    endtask

    initial begin
        clrn         = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        div_busy     = 1'b0;
        div_ready    = 1'b0;
        div_quotient = '0;
        div_rem      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_busy", arb_busy, 0);
        chk("rst_start", div_start, 0);
        chk("rst_quot", rsp_quotient, 0);
        chk("rst_state", state_dbg, 0);
        @(negedge clk);
        clrn = 1'b1;

        // All four requesting from ptr=0: grants 0,1,2,3 in order
        @(negedge clk);
        set_ops(0, 32'h4060_0000, 32'h4000_0000);
        set_ops(1, 32'h4120_0000, 32'h4000_0000);
        set_ops(2, 32'h3F80_0000, 32'h4040_0000);
        set_ops(3, 32'h4100_0000, 32'h4080_0000);
        req_valid = 4'b1111;
        serve(0, 32'h4060_0000, 32'h4000_0000, 32'h3FE0_0000, 32'h0, 1, '0, '0, 0);
        serve(1, 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000, 32'h0, 0, '0, '0, 0);
        serve(2, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 32'h1, 2, '0, '0, 0);
        serve(3, 32'h4100_0000, 32'h4080_0000, 32'h4000_0000, 32'h0, 1, '0, '0, 0);

        // Single request 3.5/2 on port 0 (ptr wrapped back to 0)
        set_ops(0, 32'h4060_0000, 32'h4000_0000);
        req_valid = 4'b0001;
        serve(0, 32'h4060_0000, 32'h4000_0000, 32'h3FE0_0000, 32'h0, 3, '0, '0, 0);

        // Port 2 raised while port 1 waits: held off until port 1's response completes
        set_ops(1, 32'h40C0_0000, 32'h4040_0000);
        set_ops(2, 32'h4110_0000, 32'h4040_0000);
        req_valid = 4'b0010;
        serve(1, 32'h40C0_0000, 32'h4040_0000, 32'h4000_0000, 32'h0, 3, 4'b0100, '0, 0);
        serve(2, 32'h4110_0000, 32'h4040_0000, 32'h4040_0000, 32'h0, 1, '0, '0, 0);

        // Reset during WAIT: everything clears, pointer returns to 0
        set_ops(0, 32'h4000_0000, 32'h3F80_0000);
        req_valid = 4'b0001;
        #1;
        chk("rstw_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rstw_start", div_start, 1);
        @(negedge clk);
        #1;
        chk("rstw_wait", state_dbg, 2);
        @(negedge clk);
        clrn = 1'b0;
        set_ops(1, 32'h4080_0000, 32'h4000_0000);
        req_valid = 4'b0011;
        #1;
        chk("rstw_ready", req_ready, 0);
        chk("rstw_rsp", rsp_valid, 0);
        chk("rstw_busy", arb_busy, 0);
        chk("rstw_start0", div_start, 0);
        chk("rstw_dvd", div_dividend, 0);
        chk("rstw_dvs", div_divisor, 0);
        chk("rstw_quot", rsp_quotient, 0);
        chk("rstw_rem", rsp_rem, 0);
        chk("rstw_err", rsp_err, 0);
        @(negedge clk);
        #1;
        chk("rstw_norsp", rsp_valid, 0);
        @(negedge clk);
        clrn = 1'b1;
        serve(0, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h0, 1, '0, '0, 0);
        serve(1, 32'h4080_0000, 32'h4000_0000, 32'h4000_0000, 32'h0, 1, '0, '0, 0);

        // Ready during ISSUE is ignored; port 3 raised then withdrawn before any grant
        set_ops(2, 32'h4120_0000, 32'h40A0_0000);
        req_valid = 4'b0100;
        serve(2, 32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 32'h2, 2, 4'b1000, 4'b1000, 1);
        for (int i = 0; i < 3; i++) begin
            chk("withdrawn_ready", req_ready, 0);
            chk("withdrawn_rsp", rsp_valid, 0);
            @(negedge clk);
            #1;
        end

`ifdef FPU_DIV_TIMEOUT_EN
        // Divider never answers: abort after TIMEOUT WAIT cycles
        @(negedge clk);
        set_ops(3, 32'h4000_0000, 32'h4000_0000);
        req_valid = 4'b1000;
        #1;
        chk("tmo_grant", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("tmo_start", div_start, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            #1;
            chk("tmo_wait_norsp", rsp_valid, 0);
        end
        @(negedge clk);
        #1;
        chk("tmo_rsp", rsp_valid, 4'b1000);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_quot", rsp_quotient, 0);
        chk("tmo_rem", rsp_rem, 0);
        @(negedge clk);
        #1;
        chk("tmo_idle", arb_busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
